stopwatch_time_counter: RTL and testbench



---
 rtl/stopwatch_time_counter.sv | 186 ++++++++++++++++++
 tb/tb_stopwatch_time_counter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_time_counter.sv
// BCD MM:SS datapath for the stopwatch: up/down counting on a 1 s tick, lap freeze, terminal flag.
// Define STOPWATCH_HUNDREDTHS_EN to replace the binary prescaler with a visible hundredths field.
module stopwatch_time_counter #(
  parameter int unsigned TICKS_PER_SEC = 100,
  parameter int unsigned MAX_MIN_TENS  = 5
) (
  input  logic        clk_100,
  input  logic        rst,
  input  logic        count_enable,
  input  logic        lap_enable,
  input  logic        count_up_down,
  input  logic        clear,
  input  logic        load,
  input  logic [15:0] preset,
  output logic [3:0]  dig3,
  output logic [3:0]  dig2,
  output logic [3:0]  dig1,
  output logic [3:0]  dig0,
`ifdef STOPWATCH_HUNDREDTHS_EN
  output logic [3:0]  dig_h1,
  output logic [3:0]  dig_h0,
`endif
  output logic [2:0]  reset_up
);

  localparam logic [3:0]  MaxMinT  = 4'(MAX_MIN_TENS);
  localparam logic [15:0] MaxCount = {MaxMinT, 4'd9, 4'd5, 4'd9};

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] disp_q, disp_d;
  logic [2:0]  reset_up_q, reset_up_d;
  logic [15:0] cnt_inc, cnt_dec, preset_clamped;
  logic        tick, term;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  assign preset_clamped = {clamp_digit(preset[15:12], MaxMinT), clamp_digit(preset[11:8], 4'd9),
                           clamp_digit(preset[7:4], 4'd5), clamp_digit(preset[3:0], 4'd9)};

  // BCD increment with carry chain; saturation is handled by the caller.
  always_comb begin
    cnt_inc = cnt_q;
    if (cnt_q[3:0] != 4'd9) begin
      cnt_inc[3:0] = cnt_q[3:0] + 4'd1;
    end else begin
      cnt_inc[3:0] = 4'd0;
      if (cnt_q[7:4] != 4'd5) begin
        cnt_inc[7:4] = cnt_q[7:4] + 4'd1;
      end else begin
        cnt_inc[7:4] = 4'd0;
        if (cnt_q[11:8] != 4'd9) begin
          cnt_inc[11:8] = cnt_q[11:8] + 4'd1;
        end else begin
          cnt_inc[11:8]  = 4'd0;
          cnt_inc[15:12] = cnt_q[15:12] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    cnt_dec = cnt_q;
    if (cnt_q[3:0] != 4'd0) begin
      cnt_dec[3:0] = cnt_q[3:0] - 4'd1;
    end else begin
      cnt_dec[3:0] = 4'd9;
      if (cnt_q[7:4] != 4'd0) begin
        cnt_dec[7:4] = cnt_q[7:4] - 4'd1;
      end else begin
        cnt_dec[7:4] = 4'd5;
        if (cnt_q[11:8] != 4'd0) begin
          cnt_dec[11:8] = cnt_q[11:8] - 4'd1;
        end else begin
          cnt_dec[11:8]  = 4'd9;
          cnt_dec[15:12] = cnt_q[15:12] - 4'd1;
        end
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    term  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = preset_clamped;
    end else if (tick) begin
      if (!count_up_down) begin
        if (cnt_q == MaxCount) term = 1'b1;
        else                   cnt_d = cnt_inc;
      end else begin
        if (cnt_q == '0) begin
          term = 1'b1;
        end else begin
          cnt_d = cnt_dec;
          term  = (cnt_dec == '0);
        end
      end
    end
    reset_up_d = term ? 3'd2 : (count_enable ? 3'd1 : 3'd0);
    disp_d     = lap_enable ? disp_q : cnt_d;
  end

`ifdef STOPWATCH_HUNDREDTHS_EN
  logic [7:0] hund_q, hund_d, hund_step;
  logic [7:0] hdisp_q, hdisp_d;

  assign tick = count_enable && (count_up_down ? (hund_q == 8'h00) : (hund_q == 8'h99));

  always_comb begin
    hund_step = hund_q;
    if (!count_up_down) begin
      if (hund_q[3:0] != 4'd9) begin
        hund_step[3:0] = hund_q[3:0] + 4'd1;
      end else begin
        hund_step[3:0] = 4'd0;
        hund_step[7:4] = (hund_q[7:4] == 4'd9) ? 4'd0 : hund_q[7:4] + 4'd1;
      end
    end else begin
      if (hund_q[3:0] != 4'd0) begin
        hund_step[3:0] = hund_q[3:0] - 4'd1;
      end else begin
        hund_step[3:0] = 4'd9;
        hund_step[7:4] = (hund_q[7:4] == 4'd0) ? 4'd9 : hund_q[7:4] - 4'd1;
      end
    end
    hund_d = hund_q;
    if (clear || load)     hund_d = '0;
    else if (term)         hund_d = '0;
    else if (count_enable) hund_d = hund_step;
    hdisp_d = lap_enable ? hdisp_q : hund_d;
  end

  always_ff @(posedge clk_100) begin
    if (rst) begin
      hund_q  <= '0;
      hdisp_q <= '0;
    end else begin
      hund_q  <= hund_d;
      hdisp_q <= hdisp_d;
    end
  end

  assign dig_h1 = hdisp_q[7:4];
  assign dig_h0 = hdisp_q[3:0];
`else
  localparam int unsigned PW       = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc_q, presc_d;

  assign tick = count_enable && (presc_q == PrescMax);

  // Prescaler holds its phase while disabled so a pause does not lose the partial second.
  always_comb begin
    presc_d = presc_q;
    if (clear || load)     presc_d = '0;
    else if (tick)         presc_d = '0;
    else if (count_enable) presc_d = presc_q + PW'(1);
  end

  always_ff @(posedge clk_100) begin
    if (rst) presc_q <= '0;
    else     presc_q <= presc_d;
  end
`endif

  always_ff @(posedge clk_100) begin
    if (rst) begin
      cnt_q      <= '0;
      disp_q     <= '0;
      reset_up_q <= 3'd0;
    end else begin
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      reset_up_q <= reset_up_d;
    end
  end

  assign {dig3, dig2, dig1, dig0} = disp_q;
  assign reset_up = reset_up_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Directed vector bench for stopwatch_time_counter with TICKS_PER_SEC = 4.
module tb_stopwatch_time_counter;

  logic        clk_100 = 1'b0;
  logic        rst = 1'b0;
  logic        count_enable = 1'b0;
  logic        lap_enable = 1'b0;
  logic        count_up_down = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b0;
  logic [15:0] preset = '0;
  logic [3:0]  dig3, dig2, dig1, dig0;
  logic [2:0]  reset_up;
`ifdef STOPWATCH_HUNDREDTHS_EN
  logic [3:0]  dig_h1, dig_h0;
`endif

  stopwatch_time_counter #(
    .TICKS_PER_SEC(4),
    .MAX_MIN_TENS (5)
  ) dut (
    .clk_100      (clk_100),
    .rst          (rst),
    .count_enable (count_enable),
    .lap_enable   (lap_enable),
    .count_up_down(count_up_down),
    .clear        (clear),
    .load         (load),
    .preset       (preset),
    .dig3         (dig3),
    .dig2         (dig2),
    .dig1         (dig1),
    .dig0         (dig0),
`ifdef STOPWATCH_HUNDREDTHS_EN
    .dig_h1       (dig_h1),
    .dig_h0       (dig_h0),
`endif
    .reset_up     (reset_up)
  );

  always #5 clk_100 = ~clk_100;

  typedef struct {
    logic        r, c, l, en, lap, dir;
    logic [15:0] pre;
    int          cyc;
    logic [15:0] edig;
    logic [2:0]  eru;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic add(input logic r, input logic c, input logic l, input logic en,
                     input logic lap, input logic dir, input logic [15:0] pre, input int cyc,
                     input logic [15:0] edig, input logic [2:0] eru);
    vec_t v;
    v.r = r; v.c = c; v.l = l; v.en = en; v.lap = lap; v.dir = dir;
    v.pre = pre; v.cyc = cyc; v.edig = edig; v.eru = eru;
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge clk_100);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [15:0] dig();
    return {dig3, dig2, dig1, dig0};
  endfunction

  initial begin
    int n2, at2, cnt;
    logic found;

    //  r  c  l  en lap dir preset    cyc  dig       ru
    add(1, 0, 0, 0, 0, 0, 16'h0000, 1,  16'h0000, 3'd0);
    add(0, 0, 0, 1, 0, 0, 16'h0000, 40, 16'h0010, 3'd1);
    add(0, 0, 1, 1, 0, 0, 16'h5958, 1,  16'h5958, 3'd1);
    add(0, 0, 0, 1, 0, 0, 16'h0000, 4,  16'h5959, 3'd1);
    add(0, 0, 0, 1, 0, 0, 16'h0000, 3,  16'h5959, 3'd1);
    add(0, 0, 0, 1, 0, 0, 16'h0000, 1,  16'h5959, 3'd2);
    add(0, 0, 0, 1, 0, 0, 16'h0000, 1,  16'h5959, 3'd1);
    add(0, 0, 1, 1, 0, 1, 16'h0102, 1,  16'h0102, 3'd1);
    add(0, 0, 0, 1, 0, 1, 16'h0000, 4,  16'h0101, 3'd1);
    add(0, 0, 0, 1, 0, 1, 16'h0000, 4,  16'h0100, 3'd1);
    add(0, 0, 0, 1, 0, 1, 16'h0000, 4,  16'h0059, 3'd1);
    add(0, 0, 1, 1, 0, 1, 16'h0001, 1,  16'h0001, 3'd1);
    add(0, 0, 0, 1, 0, 1, 16'h0000, 4,  16'h0000, 3'd2);
    add(0, 0, 0, 1, 0, 1, 16'h0000, 4,  16'h0000, 3'd2);
    add(0, 0, 0, 1, 0, 1, 16'h0000, 1,  16'h0000, 3'd1);
    add(0, 0, 1, 1, 0, 0, 16'h0005, 1,  16'h0005, 3'd1);
    add(0, 0, 0, 1, 0, 1, 16'h0000, 4,  16'h0004, 3'd1);
    add(0, 0, 0, 1, 0, 0, 16'h0000, 4,  16'h0005, 3'd1);
    add(0, 0, 0, 1, 1, 0, 16'h0000, 12, 16'h0005, 3'd1);
    add(0, 0, 0, 1, 0, 0, 16'h0000, 1,  16'h0008, 3'd1);
    add(0, 1, 0, 1, 1, 0, 16'h0000, 1,  16'h0008, 3'd1);
    add(0, 0, 0, 1, 0, 0, 16'h0000, 1,  16'h0000, 3'd1);
    add(0, 0, 1, 1, 1, 0, 16'h1234, 1,  16'h0000, 3'd1);
    add(0, 0, 0, 1, 0, 0, 16'h0000, 1,  16'h1234, 3'd1);
    add(0, 0, 0, 1, 0, 0, 16'h0000, 2,  16'h1234, 3'd1);
    add(0, 1, 1, 1, 0, 0, 16'h4321, 1,  16'h0000, 3'd1);
    add(1, 0, 1, 1, 0, 0, 16'h4321, 1,  16'h0000, 3'd0);
    add(0, 0, 1, 0, 0, 0, 16'hFF7A, 1,  16'h5959, 3'd0);
    add(0, 0, 1, 1, 0, 0, 16'h0000, 1,  16'h0000, 3'd1);
    add(0, 0, 0, 1, 0, 0, 16'h0000, 2,  16'h0000, 3'd1);
    add(0, 0, 0, 0, 0, 0, 16'h0000, 5,  16'h0000, 3'd0);
    add(0, 0, 0, 1, 0, 0, 16'h0000, 1,  16'h0000, 3'd1);
    add(0, 0, 0, 1, 0, 0, 16'h0000, 1,  16'h0001, 3'd1);
    add(0, 0, 1, 1, 0, 0, 16'h0959, 1,  16'h0959, 3'd1);
    add(0, 0, 0, 1, 0, 0, 16'h0000, 4,  16'h1000, 3'd1);
    add(0, 0, 0, 1, 0, 1, 16'h0000, 4,  16'h0959, 3'd1);

    #2;
    foreach (vq[i]) begin
      rst = vq[i].r; clear = vq[i].c; load = vq[i].l;
      count_enable = vq[i].en; lap_enable = vq[i].lap; count_up_down = vq[i].dir;
      preset = vq[i].pre;
      step();
      rst = 1'b0; clear = 1'b0; load = 1'b0;
      for (int k = 1; k < vq[i].cyc; k++) step();
      chk($sformatf("vec%0d dig/reset_up", i), {13'd0, dig(), reset_up},
          {13'd0, vq[i].edig, vq[i].eru});
    end

    // Saturation: the terminal flag must be a single-cycle pulse after the second tick.
    rst = 1'b1; count_enable = 1'b0; lap_enable = 1'b0; count_up_down = 1'b0;
    step();
    rst = 1'b0; load = 1'b1; preset = 16'h5958; count_enable = 1'b1;
    step();
    load = 1'b0;
    n2 = 0; at2 = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (reset_up == 3'd2) begin
        n2++;
        at2 = k;
      end
    end
    chk("sat pulse count", n2, 1);
    chk("sat pulse cycle", at2, 8);
    step();
    chk("sat after pulse", {13'd0, dig(), reset_up}, {13'd0, 16'h5959, 3'd1});

    // Down terminal reached from 00:03, bounded wait on the terminal flag.
    load = 1'b1; preset = 16'h0003; count_up_down = 1'b1;
    step();
    load = 1'b0;
    cnt = 0; found = 1'b0;
    while (!found && cnt < 30) begin
      step();
      cnt++;
      if (reset_up == 3'd2) found = 1'b1;
    end
    chk("down terminal seen", {31'd0, found}, 32'd1);
    chk("down terminal cycle", cnt, 12);
    chk("down terminal dig", {16'd0, dig()}, {16'd0, 16'h0000});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
